// File: rtl/memory_game_core_np.sv
// Parametrised N-card, N-player memory game controller.
// Optional macro MEMGAME_TIMEOUT_PENALTY_EN: a turn timeout also costs one pair.
module memory_game_core_np #(
    parameter int NUM_CARDS           = 16,
    parameter int NUM_PLAYERS         = 2,
    parameter int ID_W                = 5,
    parameter int TICKS_PER_TURN      = 300,
    parameter int MISMATCH_HOLD_TICKS = 2,
    localparam int IDX_W = $clog2(NUM_CARDS),
    localparam int PL_W  = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int SC_W  = $clog2(NUM_CARDS / 2 + 1),
    localparam int T_W   = $clog2(TICKS_PER_TURN + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick_i,
    input  logic                        start_btn,
    input  logic                        click_e,
    input  logic [IDX_W-1:0]            sel_idx,
    input  logic [NUM_CARDS*ID_W-1:0]   card_id_flat,
    output logic [NUM_CARDS-1:0]        card_faceup_o,
    output logic [NUM_CARDS-1:0]        card_removed_o,
    output logic [PL_W-1:0]             current_player_o,
    output logic [NUM_PLAYERS*SC_W-1:0] pairs_flat_o,
    output logic [T_W-1:0]              time_left_o,
    output logic                        show_winner_o,
    output logic [PL_W-1:0]             winner_o,
    output logic                        tie_o
);

`ifdef MEMGAME_TIMEOUT_PENALTY_EN
    localparam bit PENALTY = 1'b1;
`else
    localparam bit PENALTY = 1'b0;
`endif

    localparam int H_W = (MISMATCH_HOLD_TICKS > 0) ? $clog2(MISMATCH_HOLD_TICKS + 1) : 1;

    localparam logic [IDX_W:0]  NC_L    = (IDX_W + 1)'(NUM_CARDS);
    localparam logic [T_W-1:0]  T_MAX   = T_W'(TICKS_PER_TURN);
    localparam logic [T_W-1:0]  T_ONE   = T_W'(1);
    localparam logic [H_W-1:0]  H_INIT  = H_W'(MISMATCH_HOLD_TICKS);
    localparam logic [H_W-1:0]  H_ONE   = H_W'(1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(NUM_CARDS / 2);
    localparam logic [PL_W-1:0] PL_LAST = PL_W'(NUM_PLAYERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK1,
        S_PICK2,
        S_COMPARE,
        S_HOLD,
        S_OVER
    } state_e;

    state_e                             state_q, state_d;
    logic [NUM_CARDS-1:0][ID_W-1:0]     ids_q, ids_d;
    logic [NUM_CARDS-1:0]               faceup_q, faceup_d;
    logic [NUM_CARDS-1:0]               removed_q, removed_d;
    logic [NUM_PLAYERS-1:0][SC_W-1:0]   score_q, score_d;
    logic [PL_W-1:0]                    player_q, player_d;
    logic [T_W-1:0]                     time_q, time_d;
    logic [H_W-1:0]                     hold_q, hold_d;
    logic [IDX_W-1:0]                   a_q, a_d;
    logic [IDX_W-1:0]                   b_q, b_d;
    logic                               show_q, show_d;
    logic [PL_W-1:0]                    winner_q, winner_d;
    logic                               tie_q, tie_d;

    logic                               valid_click;
    logic [PL_W-1:0]                    next_player;
    logic [SC_W-1:0]                    best_c;
    logic [PL_W-1:0]                    win_c;
    logic [2:0]                         cnt_c;
    logic                               tie_c;

    // A click counts only on an in-range card that is still hidden and in play.
    always_comb begin
        valid_click = 1'b0;
        if (click_e && ({1'b0, sel_idx} < NC_L)) begin
            valid_click = !removed_q[sel_idx] && !faceup_q[sel_idx];
        end
    end

    assign next_player = (player_q == PL_LAST) ? '0 : player_q + 1'b1;

    // Leader search: strict compare keeps the lowest index among equals.
    always_comb begin
        best_c = '0;
        win_c  = '0;
        cnt_c  = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (score_q[p] > best_c) begin
                best_c = score_q[p];
                win_c  = PL_W'(p);
            end
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (score_q[p] == best_c) begin
                cnt_c = cnt_c + 3'd1;
            end
        end
        tie_c = (cnt_c > 3'd1);
    end

    // Next-state and datapath updates for the game sequencer.
    always_comb begin
        state_d   = state_q;
        ids_d     = ids_q;
        faceup_d  = faceup_q;
        removed_d = removed_q;
        score_d   = score_q;
        player_d  = player_q;
        time_d    = time_q;
        hold_d    = hold_q;
        a_d       = a_q;
        b_d       = b_q;
        show_d    = show_q;
        winner_d  = winner_q;
        tie_d     = tie_q;

        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start_btn) begin
                    ids_d     = card_id_flat;
                    faceup_d  = '0;
                    removed_d = '0;
                    score_d   = '0;
                    show_d    = 1'b0;
                    winner_d  = '0;
                    tie_d     = 1'b0;
                    player_d  = '0;
                    time_d    = T_MAX;
                    state_d   = S_PICK1;
                end else if (state_q == S_OVER) begin
                    show_d   = 1'b1;
                    winner_d = win_c;
                    tie_d    = tie_c;
                end
            end

            S_PICK1, S_PICK2: begin
                if (valid_click) begin
                    faceup_d[sel_idx] = 1'b1;
                    if (state_q == S_PICK1) begin
                        a_d     = sel_idx;
                        state_d = S_PICK2;
                    end else begin
                        b_d     = sel_idx;
                        state_d = S_COMPARE;
                    end
                end
                if (tick_i) begin
                    if (time_q > T_ONE) begin
                        time_d = time_q - T_ONE;
                    end else if (!valid_click) begin
                        faceup_d = '0;
                        player_d = next_player;
                        time_d   = T_MAX;
                        state_d  = S_PICK1;
                        if (PENALTY && score_q[player_q] != '0) begin
                            score_d[player_q] = score_q[player_q] - 1'b1;
                        end
                    end
                end
            end

            S_COMPARE: begin
                if (ids_q[a_q] == ids_q[b_q]) begin
                    removed_d[a_q] = 1'b1;
                    removed_d[b_q] = 1'b1;
                    faceup_d[a_q]  = 1'b0;
                    faceup_d[b_q]  = 1'b0;
                    if (score_q[player_q] < SC_MAX) begin
                        score_d[player_q] = score_q[player_q] + 1'b1;
                    end
                    time_d  = T_MAX;
                    state_d = (&removed_d) ? S_OVER : S_PICK1;
                end else begin
                    hold_d  = H_INIT;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                if (hold_q == '0 || (tick_i && hold_q == H_ONE)) begin
                    faceup_d[a_q] = 1'b0;
                    faceup_d[b_q] = 1'b0;
                    player_d      = next_player;
                    time_d        = T_MAX;
                    state_d       = S_PICK1;
                end else if (tick_i) begin
                    hold_d = hold_q - H_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ids_q     <= '0;
            faceup_q  <= '0;
            removed_q <= '0;
            score_q   <= '0;
            player_q  <= '0;
            time_q    <= T_MAX;
            hold_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            show_q    <= 1'b0;
            winner_q  <= '0;
            tie_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ids_q     <= ids_d;
            faceup_q  <= faceup_d;
            removed_q <= removed_d;
            score_q   <= score_d;
            player_q  <= player_d;
            time_q    <= time_d;
            hold_q    <= hold_d;
            a_q       <= a_d;
            b_q       <= b_d;
            show_q    <= show_d;
            winner_q  <= winner_d;
            tie_q     <= tie_d;
        end
    end

    assign card_faceup_o    = faceup_q;
    assign card_removed_o   = removed_q;
    assign current_player_o = player_q;
    assign pairs_flat_o     = score_q;
    assign time_left_o      = time_q;
    assign show_winner_o    = show_q;
    assign winner_o         = winner_q;
    assign tie_o            = tie_q;

endmodule

// File: tb/tb_memory_game_core_np.sv
// Random-stimulus scoreboard bench for memory_game_core_np.
// Reference model tracks the game with plain arrays and integers.
module tb_memory_game_core_np;

    localparam int NC  = 12;
    localparam int NP  = 3;
    localparam int IDW = 5;
    localparam int TPT = 4;
    localparam int MH  = 2;
    localparam int IXW = 4;
    localparam int PLW = 2;
    localparam int SCW = 3;
    localparam int TW  = 3;

`ifdef MEMGAME_TIMEOUT_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_JUDGE = 2;
    localparam int M_SHOW = 3;
    localparam int M_OVER = 4;

    typedef struct packed {
        logic [NC-1:0]     up;
        logic [NC-1:0]     gone;
        logic [PLW-1:0]    player;
        logic [NP*SCW-1:0] pairs;
        logic [TW-1:0]     tl;
        logic              show;
        logic [PLW-1:0]    win;
        logic              tie;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               tick_i;
    logic               start_btn;
    logic               click_e;
    logic [IXW-1:0]     sel_idx;
    logic [NC*IDW-1:0]  card_id_flat;
    logic [NC-1:0]      card_faceup_o;
    logic [NC-1:0]      card_removed_o;
    logic [PLW-1:0]     current_player_o;
    logic [NP*SCW-1:0]  pairs_flat_o;
    logic [TW-1:0]      time_left_o;
    logic               show_winner_o;
    logic [PLW-1:0]     winner_o;
    logic               tie_o;

    memory_game_core_np #(
        .NUM_CARDS          (NC),
        .NUM_PLAYERS        (NP),
        .ID_W               (IDW),
        .TICKS_PER_TURN     (TPT),
        .MISMATCH_HOLD_TICKS(MH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tick_i          (tick_i),
        .start_btn       (start_btn),
        .click_e         (click_e),
        .sel_idx         (sel_idx),
        .card_id_flat    (card_id_flat),
        .card_faceup_o   (card_faceup_o),
        .card_removed_o  (card_removed_o),
        .current_player_o(current_player_o),
        .pairs_flat_o    (pairs_flat_o),
        .time_left_o     (time_left_o),
        .show_winner_o   (show_winner_o),
        .winner_o        (winner_o),
        .tie_o           (tie_o)
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_pass  = 0;
    exp_t exp_q[$];

    int m_mode;
    int m_id[NC];
    bit m_up[NC];
    bit m_gone[NC];
    int m_score[NP];
    int m_player;
    int m_time;
    int m_hold;
    int m_first;
    int m_second;
    int m_picks;
    bit m_show;
    int m_win;
    bit m_tie;
    int games_done = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, want);
    endtask

    task automatic mreset();
        m_mode = M_IDLE;
        for (int k = 0; k < NC; k++) begin
            m_id[k] = 0; m_up[k] = 0; m_gone[k] = 0;
        end
        for (int p = 0; p < NP; p++) m_score[p] = 0;
        m_player = 0; m_time = TPT; m_hold = 0;
        m_first = 0; m_second = 0; m_picks = 0;
        m_show = 0; m_win = 0; m_tie = 0;
    endtask

    task automatic pass_turn();
        m_player = (m_player + 1) % NP;
        m_time   = TPT;
        m_picks  = 0;
        m_mode   = M_PLAY;
    endtask

    // Advance the reference model by one clock edge with the given inputs.
    task automatic mstep(input bit st, input bit ck, input int idx,
                         input bit tk, input logic [NC*IDW-1:0] idf);
        bit valid;
        int mx, cnt;
        bit all_gone;
        valid = ck && idx < NC;
        if (valid) valid = !m_gone[idx] && !m_up[idx];
        case (m_mode)
            M_IDLE, M_OVER: begin
                if (st) begin
                    for (int k = 0; k < NC; k++) begin
                        m_id[k] = int'(idf[k*IDW +: IDW]);
                        m_up[k] = 0; m_gone[k] = 0;
                    end
                    for (int p = 0; p < NP; p++) m_score[p] = 0;
                    m_show = 0; m_win = 0; m_tie = 0;
                    m_player = 0; m_time = TPT; m_picks = 0;
                    m_mode = M_PLAY;
                end else if (m_mode == M_OVER) begin
                    mx = 0;
                    foreach (m_score[p]) if (m_score[p] > mx) mx = m_score[p];
                    cnt = 0; m_win = -1;
                    foreach (m_score[p]) if (m_score[p] == mx) begin
                        cnt++;
                        if (m_win < 0) m_win = p;
                    end
                    m_show = 1;
                    m_tie = (cnt > 1);
                end
            end
            M_PLAY: begin
                if (valid) begin
                    m_up[idx] = 1;
                    if (m_picks == 0) begin m_first = idx; m_picks = 1; end
                    else begin m_second = idx; m_mode = M_JUDGE; end
                end
                if (tk) begin
                    if (m_time > 1) m_time--;
                    else if (!valid) begin
                        for (int k = 0; k < NC; k++) m_up[k] = 0;
                        if (PEN && m_score[m_player] > 0) m_score[m_player]--;
                        pass_turn();
                    end
                end
            end
            M_JUDGE: begin
                if (m_id[m_first] == m_id[m_second]) begin
                    m_gone[m_first] = 1; m_gone[m_second] = 1;
                    m_up[m_first] = 0; m_up[m_second] = 0;
                    if (m_score[m_player] < NC / 2) m_score[m_player]++;
                    m_time = TPT; m_picks = 0;
                    all_gone = 1;
                    foreach (m_gone[k]) if (!m_gone[k]) all_gone = 0;
                    if (all_gone) begin m_mode = M_OVER; games_done++; end
                    else m_mode = M_PLAY;
                end else begin
                    m_hold = MH;
                    m_mode = M_SHOW;
                end
            end
            M_SHOW: begin
                if (m_hold > 0 && tk) m_hold--;
                if (m_hold == 0) begin
                    m_up[m_first] = 0; m_up[m_second] = 0;
                    pass_turn();
                end
            end
            default: ;
        endcase
    endtask

    function automatic exp_t snap();
        exp_t e;
        e = '0;
        for (int k = 0; k < NC; k++) begin
            e.up[k] = m_up[k]; e.gone[k] = m_gone[k];
        end
        for (int p = 0; p < NP; p++) e.pairs[p*SCW +: SCW] = SCW'(m_score[p]);
        e.player = PLW'(m_player);
        e.tl     = TW'(m_time);
        e.show   = m_show;
        e.win    = PLW'(m_win);
        e.tie    = m_tie;
        return e;
    endfunction

    // Monitor: one expected snapshot per clock edge, sampled 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("faceup",  64'(card_faceup_o),    64'(e.up));
                chk("removed", 64'(card_removed_o),   64'(e.gone));
                chk("player",  64'(current_player_o), 64'(e.player));
                chk("pairs",   64'(pairs_flat_o),     64'(e.pairs));
                chk("time",    64'(time_left_o),      64'(e.tl));
                chk("show",    64'(show_winner_o),    64'(e.show));
                chk("winner",  64'(winner_o),         64'(e.win));
                chk("tie",     64'(tie_o),            64'(e.tie));
            end
        end
    end

    // Driver: random game play with steered clicks so games complete.
    initial begin
        int perm[NC];
        int j, t, idx, r;
        bit st, ck, tk, do_rst;
        int cand[$];
        logic [NC*IDW-1:0] idf;

        rst_n = 1'b0; tick_i = 1'b0; start_btn = 1'b0;
        click_e = 1'b0; sel_idx = '0; card_id_flat = '0;
        mreset();

        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            for (int k = 0; k < NC; k++) perm[k] = k >> 1;
            for (int k = NC - 1; k > 0; k--) begin
                j = $urandom_range(0, k);
                t = perm[k]; perm[k] = perm[j]; perm[j] = t;
            end
            for (int k = 0; k < NC; k++) idf[k*IDW +: IDW] = IDW'(perm[k]);

            if (m_mode == M_IDLE || m_mode == M_OVER)
                st = ($urandom_range(0, 3) == 0);
            else
                st = ($urandom_range(0, 199) == 0);
            tk = ($urandom_range(0, 3) == 0);
            ck = ($urandom_range(0, 1) == 1);

            r = $urandom_range(0, 9);
            idx = $urandom_range(0, 15);
            if (r < 5 && m_mode == M_PLAY && m_picks == 1) begin
                for (int k = 0; k < NC; k++)
                    if (k != m_first && m_id[k] == m_id[m_first]) idx = k;
            end else if (r < 8) begin
                cand.delete();
                for (int k = 0; k < NC; k++)
                    if (!m_gone[k] && !m_up[k]) cand.push_back(k);
                if (cand.size() > 0)
                    idx = cand[$urandom_range(0, cand.size() - 1)];
            end

            do_rst = (c < 2) || (c == 7000) || ($urandom_range(0, 2999) == 0);

            tick_i = tk; start_btn = st; click_e = ck;
            sel_idx = IXW'(idx); card_id_flat = idf;
            if (do_rst) begin
                rst_n = 1'b0;
                mreset();
            end else begin
                rst_n = 1'b1;
                mstep(st, ck, idx, tk, idf);
            end
            exp_q.push_back(snap());
        end

        @(posedge clk);
        #2;
        chk("drain", 64'(exp_q.size()), 64'(0));
        $display("games completed: %0d", games_done);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/memory_game_core_np.md
Name: memory_game_core_np

Overview:
- Parametrised successor to the fixed 16-card, 2-player memory game controller. Generalises card count, player count and turn timing.
- Adds a mismatch display hold, per-turn countdown with timeout, match-keeps-turn rule, and winner/tie resolution across N players.
- Sits between the debounced START/CLICK pulses and the video generator, 7-segment decoders and turn LEDs.

Parameters:
- NUM_CARDS, 16, total cards; even, 4..64.
- NUM_PLAYERS, 2, players in rotation; 2..4.
- ID_W, 5, width of one card pair-ID.
- TICKS_PER_TURN, 300, tick_i pulses allowed per turn.
- MISMATCH_HOLD_TICKS, 2, tick_i pulses a mismatched pair stays face-up.
- Derived: IDX_W=$clog2(NUM_CARDS); PL_W=max(1,$clog2(NUM_PLAYERS)); SC_W=$clog2(NUM_CARDS/2+1); T_W=$clog2(TICKS_PER_TURN+1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick_i  in  1  single-cycle timebase pulse.
- start_btn  in  1  single-cycle start pulse.
- click_e  in  1  single-cycle select pulse.
- sel_idx  in  IDX_W  card index sampled with click_e.
- card_id_flat  in  NUM_CARDS*ID_W  pair-ID of card k at bits [k*ID_W +: ID_W]; sampled on start.
- card_faceup_o  out  NUM_CARDS  face-up mask.
- card_removed_o  out  NUM_CARDS  matched/removed mask.
- current_player_o  out  PL_W  active player.
- pairs_flat_o  out  NUM_PLAYERS*SC_W  pair count per player.
- time_left_o  out  T_W  remaining ticks in turn.
- show_winner_o  out  1  game over.
- winner_o  out  PL_W  winning player (lowest index among leaders).
- tie_o  out  1  more than one player shares the max score.

Behaviour:
- Reset: all outputs 0 except time_left_o=TICKS_PER_TURN; state IDLE.
- States: IDLE, PICK1, PICK2, COMPARE, HOLD, GAME_OVER.
- IDLE/GAME_OVER + start_btn:
  - latch card_id_flat; clear masks, scores, show_winner_o, tie_o, winner_o.
  - player=0, time_left=TICKS_PER_TURN; next cycle PICK1.
- start_btn in any other state: ignored.
- Valid click: sel_idx<NUM_CARDS, card not removed, card not face-up. Invalid clicks are ignored with no state change.
- PICK1 + valid click: set faceup bit, store idx as A; next state PICK2.
- PICK2 + valid click: set faceup bit, store idx as B; next state COMPARE.
- COMPARE (exactly one cycle):
  - ID[A]==ID[B]: set removed bits A,B; clear their faceup bits; score[player]+1; player unchanged; time_left reload.
    - If removed mask now all-ones, go to GAME_OVER; otherwise PICK1.
  - Else: go to HOLD with hold counter=MISMATCH_HOLD_TICKS.
- HOLD: decrement on tick_i; clicks ignored; turn timer frozen.
  - At 0: clear faceup A,B; player=(player+1) mod NUM_PLAYERS; time_left reload; go to PICK1.
  - Wrap: player NUM_PLAYERS-1 goes to 0.
- Turn timer: decrements on tick_i only in PICK1/PICK2.
  - Tick with time_left==1 is a timeout: clear all faceup bits, advance player, reload, go to PICK1.
  - Same-cycle valid click and timeout: click processed, timeout discarded, time_left holds at 1.
- GAME_OVER, registered one cycle after entry:
  - show_winner_o=1; winner_o = lowest index with max score; tie_o = count of players at max > 1.
- Scores saturate at NUM_CARDS/2.
- Async reset mid-game returns to IDLE immediately; masks cleared.

Optional Feature:
- Macro MEMGAME_TIMEOUT_PENALTY_EN.
- Defined: a timeout also decrements score[player], saturating at 0. The game still ends on the removed mask only.
- Undefined: a timeout only passes the turn; scores are untouched.

Test Plan:
- NUM_CARDS=16, NUM_PLAYERS=2, IDs k>>1. Start, click 0 then 1 -> next cycle removed=0x0003, faceup=0, score P0=1, current_player_o=0, time_left=300.
- Click 0 then 2 (mismatch) -> faceup=0x0005 for 2 ticks; clicks ignored during hold; after the 2nd tick faceup=0, player=1.
- Click idx 0 twice, click a removed card, click idx 17 with NUM_CARDS=16 padding -> no state change, faceup unchanged.
- TICKS_PER_TURN=3: one card up, 3 ticks -> faceup=0, player advanced. Valid click on the same cycle as the 3rd tick -> click taken, time_left=1.
- NUM_PLAYERS=3, full game, scores 3/3/2 -> show_winner_o=1, winner_o=0, tie_o=1. Async reset mid-game -> all outputs at reset values.
- With MEMGAME_TIMEOUT_PENALTY_EN, P0 at score 1 times out -> score 0. A second timeout -> score stays 0.
